// File: rtl/gpio_access_arb.sv
// Two-master round-robin arbiter serialising single-cycle commands onto the GPIO register interface.
// Optional exclusive-ownership locking is enabled by defining GPIO_ARB_LOCK_EN.
module gpio_access_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_busy_o,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_busy_o,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_wen_o,
  output logic              reg_ren_o,
  input  logic [DATA_W-1:0] reg_rdata_i
`ifdef GPIO_ARB_LOCK_EN
  ,
  input  logic              m0_lock_i,
  input  logic              m1_lock_i
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

  state_t            state_q;
  logic [1:0]        req_w, we_w;
  logic [ADDR_W-1:0] addr_w  [2];
  logic [DATA_W-1:0] wdata_w [2];

  logic [1:0]        pend_q, we_q, ack_q;
  logic [ADDR_W-1:0] addr_q  [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic              gnt_q, last_q;

  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              reg_wen_q, reg_ren_q;

  logic [1:0]        elig;
  logic              pick, other;

  assign req_w      = {m1_req_i, m0_req_i};
  assign we_w       = {m1_we_i, m0_we_i};
  assign addr_w[0]  = m0_addr_i;
  assign addr_w[1]  = m1_addr_i;
  assign wdata_w[0] = m0_wdata_i;
  assign wdata_w[1] = m1_wdata_i;

`ifdef GPIO_ARB_LOCK_EN
  logic [1:0] lock_w, lock_q;
  logic       own_vld_q, own_q, own_vld_d, own_d;

  assign lock_w = {m1_lock_i, m0_lock_i};

  // Ownership is resolved in the RESP cycle so the re-arbitration in that same cycle already sees it.
  always_comb begin
    own_vld_d = own_vld_q;
    own_d     = own_q;
    if (state_q == S_RESP) begin
      if (lock_q[gnt_q]) begin
        own_vld_d = 1'b1;
        own_d     = gnt_q;
      end else if (own_q == gnt_q) begin
        own_vld_d = 1'b0;
      end
    end
  end

  assign elig = own_vld_d ? (pend_q & (own_d ? 2'b10 : 2'b01)) : pend_q;
`else
  assign elig = pend_q;
`endif

  assign pick  = (elig == 2'b11) ? ~last_q : elig[1];
  assign other = ~gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      we_q        <= '0;
      ack_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
      reg_ren_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i[0]]  <= '0;
        wdata_q[i[0]] <= '0;
        rdata_q[i[0]] <= '0;
      end
`ifdef GPIO_ARB_LOCK_EN
      lock_q    <= '0;
      own_vld_q <= 1'b0;
      own_q     <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (req_w[i[0]] && !pend_q[i[0]]) begin
          pend_q[i[0]]  <= 1'b1;
          we_q[i[0]]    <= we_w[i[0]];
          addr_q[i[0]]  <= addr_w[i[0]];
          wdata_q[i[0]] <= wdata_w[i[0]];
`ifdef GPIO_ARB_LOCK_EN
          lock_q[i[0]]  <= lock_w[i[0]];
`endif
        end
      end

      ack_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
      reg_ren_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (elig != 2'b00) begin
            gnt_q       <= pick;
            last_q      <= pick;
            reg_addr_q  <= addr_q[pick];
            reg_wdata_q <= wdata_q[pick];
            reg_wen_q   <= we_q[pick];
            reg_ren_q   <= ~we_q[pick];
            state_q     <= S_XFER;
          end
        end
        S_XFER: begin
          rdata_q[gnt_q] <= we_q[gnt_q] ? '0 : reg_rdata_i;
          ack_q[gnt_q]   <= 1'b1;
          state_q        <= S_RESP;
        end
        S_RESP: begin
          pend_q[gnt_q] <= 1'b0;
          if (elig[other]) begin
            gnt_q       <= other;
            last_q      <= other;
            reg_addr_q  <= addr_q[other];
            reg_wdata_q <= wdata_q[other];
            reg_wen_q   <= we_q[other];
            reg_ren_q   <= ~we_q[other];
            state_q     <= S_XFER;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef GPIO_ARB_LOCK_EN
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
`endif
    end
  end

  assign m0_busy_o   = pend_q[0];
  assign m1_busy_o   = pend_q[1];
  assign m0_ack_o    = ack_q[0];
  assign m1_ack_o    = ack_q[1];
  assign m0_rdata_o  = rdata_q[0];
  assign m1_rdata_o  = rdata_q[1];
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_wen_o   = reg_wen_q;
  assign reg_ren_o   = reg_ren_q;

endmodule
